// File: rtl/uart_cmd_dispatch.sv
// rtl/uart_cmd_dispatch.sv - 24-bit UART command dispatcher with config registers
// and a UART transmitter shared with a one-byte telemetry requester.
module uart_cmd_dispatch #(
    parameter int          NUM_REGS = 4,
    parameter logic [7:0]  ACK_BYTE = 8'hA5,
    parameter logic [7:0]  NAK_BYTE = 8'hEE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_rdy,
    input  logic [23:0]             cmd,
    output logic                    clr_cmd_rdy,
    output logic                    trmt,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    input  logic                    tel_req,
    input  logic [7:0]              tel_data,
    output logic                    tel_ack,
    output logic [16*NUM_REGS-1:0]  cfg,
    output logic                    go
);

    typedef enum logic [2:0] {IDLE, DECODE, SEND1, WAIT1, SEND2, WAIT2} state_t;

    localparam logic [4:0] NREG = 5'(NUM_REGS);

    state_t                 state, state_n;
    logic                   cmd_first;
    logic [23:0]            cmd_q;
    logic [7:0]             byte2;
    logic                   two_byte;
    logic                   first_wait;
    logic [16*NUM_REGS-1:0] cfg_q;
    logic                   go_q;
    logic [7:0]             tx_data_q;
    logic                   grant_cmd, grant_tel;

    logic [3:0]  opcode, addr;
    logic [15:0] data, rd_val;
    logic        addr_ok, is_wr, is_rd, is_go;
    logic [7:0]  resp1;

    assign opcode  = cmd_q[23:20];
    assign addr    = cmd_q[19:16];
    assign data    = cmd_q[15:0];
    assign addr_ok = {1'b0, addr} < NREG;
    assign is_wr   = addr_ok && (opcode == 4'h1);
    assign is_rd   = addr_ok && (opcode == 4'h2);
    assign is_go   = addr_ok && (opcode == 4'h3);

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == 4'(i)) rd_val = cfg_q[16*i +: 16];
        end
    end

    assign resp1 = is_rd ? rd_val[15:8] : ((is_wr || is_go) ? ACK_BYTE : NAK_BYTE);

    always_comb begin
        state_n     = state;
        clr_cmd_rdy = 1'b0;
        tel_ack     = 1'b0;
        trmt        = 1'b0;
        grant_cmd   = 1'b0;
        grant_tel   = 1'b0;
        case (state)
            IDLE: begin
                // Pointer only matters when both requesters are waiting.
                if (cmd_rdy && (cmd_first || !tel_req)) begin
                    grant_cmd   = 1'b1;
                    clr_cmd_rdy = 1'b1;
                    state_n     = DECODE;
                end else if (tel_req) begin
                    grant_tel = 1'b1;
                    tel_ack   = 1'b1;
                    state_n   = SEND1;
                end
            end
            DECODE: state_n = SEND1;
            SEND1: begin
                trmt    = 1'b1;
                state_n = WAIT1;
            end
            WAIT1: begin
                if (!first_wait && tx_done) state_n = two_byte ? SEND2 : IDLE;
            end
            SEND2: begin
                trmt    = 1'b1;
                state_n = WAIT2;
            end
            WAIT2: begin
                if (!first_wait && tx_done) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_first  <= 1'b1;
            cmd_q      <= '0;
            byte2      <= '0;
            two_byte   <= 1'b0;
            first_wait <= 1'b0;
            cfg_q      <= '0;
            go_q       <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state      <= state_n;
            // tx_done may still be high from the previous byte right after trmt.
            first_wait <= trmt;
            go_q       <= (state == DECODE) && is_go;
            if (grant_cmd) begin
                cmd_q     <= cmd;
                cmd_first <= 1'b0;
            end
            if (grant_tel) begin
                tx_data_q <= tel_data;
                two_byte  <= 1'b0;
                cmd_first <= 1'b1;
            end
            if (state == DECODE) begin
                tx_data_q <= resp1;
                byte2     <= rd_val[7:0];
                two_byte  <= is_rd;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (is_wr && addr == 4'(i)) cfg_q[16*i +: 16] <= data;
                end
            end
            if (state == WAIT1 && state_n == SEND2) tx_data_q <= byte2;
        end
    end

    assign tx_data = tx_data_q;
    assign cfg     = cfg_q;
    assign go      = go_q;

endmodule

// File: tb/tb_uart_cmd_dispatch.sv
// tb/tb_uart_cmd_dispatch.sv - randomized self-checking bench for uart_cmd_dispatch
// with a behavioural command/telemetry/transmitter model.
module tb_uart_cmd_dispatch;

    localparam int NUM_REGS = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   cmd_rdy = 1'b0;
    logic [23:0]            cmd = '0;
    logic                   clr_cmd_rdy;
    logic                   trmt;
    logic [7:0]             tx_data;
    logic                   tx_done = 1'b1;
    logic                   tel_req = 1'b0;
    logic [7:0]             tel_data = '0;
    logic                   tel_ack;
    logic [16*NUM_REGS-1:0] cfg;
    logic                   go;

    uart_cmd_dispatch #(.NUM_REGS(NUM_REGS), .ACK_BYTE(8'hA5), .NAK_BYTE(8'hEE)) dut (
        .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .clr_cmd_rdy(clr_cmd_rdy),
        .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .tel_req(tel_req),
        .tel_data(tel_data), .tel_ack(tel_ack), .cfg(cfg), .go(go)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    logic [15:0] mcfg [NUM_REGS];
    logic [7:0]  exp_q [$];
    int          trmt_due = 0, idle_from = 0, go_due = -1, wr_due = -1, wr_addr = 0;
    logic [15:0] wr_data = '0;
    bit          tx_busy = 0;
    int          tx_age = 0, tx_low = 0;
    logic [7:0]  tx_cur = '0;
    bit          rand_idle_done = 0;
    bit          rst_drv = 1, cmd_pend = 0, tel_pend = 0, tel_hold = 0, cmd_turn = 1;
    logic [23:0] cmd_val = '0;
    logic [7:0]  tel_val = '0;
    int          n_trmt = 0, n_cmd = 0, n_tel = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] r = '0;
        for (int i = 0; i < NUM_REGS; i++) r[16*i +: 16] = mcfg[i];
        return r;
    endfunction

    task automatic model_cmd(input logic [23:0] c);
        logic [3:0] op = c[23:20];
        int         a  = int'(c[19:16]);
        bit         ok = (a < NUM_REGS);
        if (ok && op == 4'h1) begin
            wr_due = cycle + 2; wr_addr = a; wr_data = c[15:0];
            exp_q.push_back(8'hA5);
        end else if (ok && op == 4'h2) begin
            exp_q.push_back(mcfg[a][15:8]);
            exp_q.push_back(mcfg[a][7:0]);
        end else if (ok && op == 4'h3) begin
            go_due = cycle + 2;
            exp_q.push_back(8'hA5);
        end else begin
            exp_q.push_back(8'hEE);
        end
        trmt_due = cycle + 2;
    endtask

    task automatic monitor();
        bit allowed, exp_cmd, exp_tel;
        if (rst) return;
        allowed = !tx_busy && exp_q.size() == 0 && trmt_due == 0 && cycle >= idle_from;
        exp_cmd = allowed && cmd_rdy && (cmd_turn || !tel_req);
        exp_tel = allowed && tel_req && !exp_cmd;

        if (cycle == wr_due) begin
            mcfg[wr_addr] = wr_data;
            check("cfg_after_write", cfg, model_flat());
        end
        if (go || cycle == go_due) check("go_pulse", go, cycle == go_due);

        if (tx_busy && !trmt) check("tx_data_hold", tx_data, tx_cur);
        if (trmt) begin
            n_trmt++;
            check("trmt_while_busy", tx_busy, 0);
            check("trmt_expected", exp_q.size() != 0, 1);
            check("trmt_time", cycle, trmt_due);
            if (exp_q.size() != 0) check("tx_data", tx_data, exp_q.pop_front());
            trmt_due = 0;
        end else if (trmt_due == cycle) begin
            check("trmt_missing", 0, 1);
            trmt_due = 0;
        end
        if (tx_busy && tx_age >= 2 && tx_done) begin
            tx_busy = 0;
            if (exp_q.size() != 0) trmt_due = cycle + 1;
            else idle_from = cycle + 1;
        end
        if (trmt) begin
            tx_busy = 1; tx_age = 0; tx_low = $urandom_range(0, 3); tx_cur = tx_data;
        end

        if (clr_cmd_rdy || exp_cmd) check("clr_cmd_rdy", clr_cmd_rdy, exp_cmd);
        if (tel_ack || exp_tel) check("tel_ack", tel_ack, exp_tel);
        if (exp_cmd && clr_cmd_rdy) begin
            check("cfg_at_grant", cfg, model_flat());
            model_cmd(cmd_val);
            cmd_pend = 0; cmd_turn = 0; n_cmd++;
        end
        if (exp_tel && tel_ack) begin
            exp_q.push_back(tel_val);
            trmt_due = cycle + 1;
            cmd_turn = 1; n_tel++;
            if (!tel_hold) tel_pend = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        rst      = rst_drv;
        cmd_rdy  = cmd_pend;
        cmd      = cmd_val;
        tel_req  = tel_pend;
        tel_data = tel_val;
        if (tx_busy) begin
            tx_age++;
            if (tx_age >= 2) tx_done = (tx_age >= 2 + tx_low);
        end else if (rand_idle_done) begin
            tx_done = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        monitor();
    endtask

    task automatic do_reset();
        rst_drv = 1; cmd_pend = 0; tel_pend = 0; tel_hold = 0;
        step();
        step();
        for (int i = 0; i < NUM_REGS; i++) mcfg[i] = '0;
        exp_q.delete();
        tx_busy = 0; trmt_due = 0; go_due = -1; wr_due = -1; cmd_turn = 1;
        rst_drv = 0;
        idle_from = cycle + 1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (!cmd_pend && !tel_pend && exp_q.size() == 0 && !tx_busy && trmt_due == 0) return;
            step();
        end
        check("idle_timeout", 0, 1);
    endtask

    task automatic send(input logic [23:0] c);
        cmd_pend = 1; cmd_val = c;
        wait_idle();
    endtask

    task automatic wait_cmd_taken();
        for (int i = 0; i < 500; i++) begin
            if (!cmd_pend) return;
            step();
        end
        check("cmd_take_timeout", 0, 1);
    endtask

    initial begin
        int base;
        logic [3:0] op, ad;
        do_reset();
        step();
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_trmt", trmt, 0);
        check("rst_go", go, 0);
        check("rst_clr", clr_cmd_rdy, 0);
        check("rst_tel_ack", tel_ack, 0);
        check("rst_cfg", cfg, 64'h0);

        send(24'h10_1234);
        check("write_r0", cfg[15:0], 16'h1234);
        send(24'h12_BEEF);
        send(24'h22_0000);
        check("write_r2", cfg[47:32], 16'hBEEF);
        send(24'h30_0000);
        send(24'h70_0000);
        send(24'h15_0001);
        check("nak_cfg_unchanged", cfg, 64'h0000_BEEF_0000_1234);

        // Contention: telemetry held high while commands arrive back to back.
        tel_val = 8'h3C; tel_hold = 1; tel_pend = 1;
        base = n_tel;
        for (int k = 0; k < 6; k++) begin
            cmd_pend = 1; cmd_val = {4'h2, 4'(k % 4), 16'h0};
            wait_cmd_taken();
        end
        tel_hold = 0;
        wait_idle();
        check("tel_alternation", (n_tel - base) >= 6, 1);

        // Random traffic with varying transmitter timing.
        rand_idle_done = 1;
        for (int k = 0; k < 150; k++) begin
            if (!cmd_pend) begin
                op = 4'($urandom_range(0, 4));
                ad = 4'($urandom_range(0, 5));
                cmd_pend = 1; cmd_val = {op, ad, 16'($urandom)};
            end
            if (!tel_pend && $urandom_range(0, 2) == 0) begin
                tel_pend = 1; tel_val = 8'($urandom);
            end
            repeat ($urandom_range(0, 20)) step();
        end
        wait_idle();
        rand_idle_done = 0;
        tx_done = 1'b1;
        check("cfg_after_random", cfg, model_flat());

        // Reset while the second byte of a READ is outstanding.
        send(24'h11_5A5A);
        base = n_trmt;
        cmd_pend = 1; cmd_val = 24'h21_0000;
        for (int i = 0; i < 200 && n_trmt < base + 2; i++) step();
        check("read_two_trmt", n_trmt - base, 2);
        do_reset();
        step();
        check("mid_rst_cfg", cfg, 64'h0);
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_trmt", trmt, 0);
            step();
        end
        send(24'h13_C0DE);
        check("post_rst_write", cfg[63:48], 16'hC0DE);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_dispatch.md
Name: uart_cmd_dispatch

Overview:
- Controller between the 3-byte UART command receiver/transmitter wrapper and the rest of the design.
- Consumes each 24-bit command, then either writes a config register, reads one back, or fires a go pulse, and returns a response over the UART transmitter.
- Also arbitrates the single UART transmitter between command responses and a one-byte telemetry requester.

Parameters:
- NUM_REGS, 4, number of 16-bit config registers (1..16).
- ACK_BYTE, 8'hA5, byte sent on successful WRITE/GO.
- NAK_BYTE, 8'hEE, byte sent on illegal opcode or out-of-range address.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_rdy  in  1  full 24-bit command available from receiver wrapper.
- cmd  in  24  command: [23:20] opcode, [19:16] addr, [15:0] data.
- clr_cmd_rdy  out  1  one-cycle pulse; releases the command wrapper.
- trmt  out  1  one-cycle pulse; starts a UART byte transmission.
- tx_data  out  8  byte to transmit; held stable from trmt until tx_done.
- tx_done  in  1  transmitter finished (level; may stay high between bytes).
- tel_req  in  1  telemetry requester wants one byte sent (level, held until tel_ack).
- tel_data  in  8  telemetry byte, valid while tel_req is high.
- tel_ack  out  1  one-cycle pulse; tel_data captured.
- cfg  out  16*NUM_REGS  config registers, reg i at [16*i+15:16*i].
- go  out  1  one-cycle pulse on a legal GO command.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state IDLE.
  - clr_cmd_rdy, trmt, tel_ack, go = 0; tx_data = 0; all cfg = 0.
  - Arbitration pointer set to "command first".
  - Reset mid-transfer abandons the transfer immediately; no further trmt is issued.
- Opcodes:
  - 4'h1 WRITE: cfg[addr] <= data; respond ACK_BYTE.
  - 4'h2 READ: respond two bytes, cfg[addr][15:8] then cfg[addr][7:0].
  - 4'h3 GO: go pulse; respond ACK_BYTE.
  - Any other opcode, or addr >= NUM_REGS: no register or go effect; respond NAK_BYTE (single byte).
- FSM states: IDLE, DECODE, SEND1, WAIT1, SEND2, WAIT2.
- IDLE, with only cmd_rdy high:
  - Latch cmd; pulse clr_cmd_rdy this cycle; go to DECODE.
  - Set pointer to "telemetry first".
- IDLE, with only tel_req high:
  - Latch tel_data as byte1 (single-byte response); pulse tel_ack; go to SEND1.
  - Set pointer to "command first".
- IDLE, with both high: grant whichever the pointer selects; the other waits. This gives strict alternation under contention.
- DECODE (exactly 1 cycle): perform the WRITE/GO effect and compute the response bytes.
  - cfg updates and go pulses in the cycle after DECODE; cfg is visible in the cycle after DECODE.
  - Go to SEND1.
- SEND1: trmt=1, tx_data=byte1; go to WAIT1.
- WAIT1:
  - tx_done is ignored in the first cycle after trmt, because it can be stale high.
  - From the second cycle on, when tx_done=1: go to SEND2 if READ, else IDLE.
- SEND2 / WAIT2: same as SEND1/WAIT1 with byte2; then go to IDLE.
- Latency:
  - cmd_rdy to first trmt = 3 cycles (IDLE, DECODE, SEND1).
  - tel_req to trmt = 2 cycles.
- cmd_rdy rising during a transfer: ignored until IDLE (the wrapper holds it); it is never lost.
- tx_data holds its last value when not transmitting.
- trmt is never asserted twice without an intervening qualified tx_done.
- A READ of a register written by the immediately preceding WRITE returns the new value.

Test Plan:
- Reset, then cmd=24'h10_1234 (WRITE r0): clr_cmd_rdy 1 cycle; cfg[15:0]=16'h1234 after DECODE; trmt with tx_data=8'hA5; return to IDLE after tx_done.
- WRITE r2=16'hBEEF, then cmd=24'h22_0000 (READ r2): two trmt pulses, tx_data 8'hBE then 8'hEF; second trmt only after the first tx_done.
- cmd=24'h3_0_0000 (GO): go high exactly 1 cycle; ACK 8'hA5 sent. cmd=24'h7_0_0000 and cmd=24'h15_0001 (addr 5, NUM_REGS=4): NAK 8'hEE sent, cfg unchanged, go stays 0.
- Hold tel_req=1 with tel_data=8'h3C, and issue back-to-back commands: responses alternate (cmd, tel, cmd, tel); tel_ack pulses once per grant; tel byte 8'h3C appears on tx_data.
- Hold tx_done=1 continuously before trmt: the FSM must wait, advancing only on tx_done sampled from the 2nd cycle after trmt; no double trmt.
- Assert rst during WAIT2 of a READ: next cycle state IDLE, cfg=0, trmt stays 0; a subsequent WRITE completes normally.
